// File: rtl/julia_pkg.sv
// Shared definitions for the Julia renderer blocks (dispatch, julia_worker,
// mem_write_arbiter).
//   NUM_WORKERS / DATA_W / ADDR_W / NUM_PIXELS : system-wide sizes
//   IDX_W      : width of a worker index
//   mc_state_t : memory-write controller states
//   wrap_inc   : worker index + 1, wrapping at NUM_WORKERS
package julia_pkg;

    localparam int NUM_WORKERS = 16;
    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 32;
    localparam int NUM_PIXELS  = 307200;
    localparam int IDX_W       = $clog2(NUM_WORKERS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } mc_state_t;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        if (int'(idx) == NUM_WORKERS - 1) begin
            return '0;
        end
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/mem_write_arbiter_if.sv
// Bus between the julia_worker array, the memory-write arbiter and the
// external pixel write port.
//   jw_mc_done[i]  : worker i holds a finished pixel (color_reg[i]/addr_reg[i])
//   mc_jw_busy[i]  : worker i's pixel is being written (one-hot)
//   mc_jw_done[i]  : single-cycle acknowledge to worker i (one-hot)
//   wr_addr/wr_data/wr_ready/wr_done : external write port
//
// Handshake: a worker raises jw_mc_done and holds it (with stable data)
// until it sees its mc_jw_done pulse. On the write port, wr_ready is the
// valid; wr_addr/wr_data stay constant while wr_ready is high, and the
// write is complete on the first rising edge where wr_ready && wr_done.
// wr_done while wr_ready is low has no meaning and is ignored.
interface mem_write_arbiter_if;
    import julia_pkg::*;

    logic [NUM_WORKERS-1:0] jw_mc_done;
    logic [DATA_W-1:0]      color_reg [NUM_WORKERS];
    logic [ADDR_W-1:0]      addr_reg  [NUM_WORKERS];
    logic                   wr_done;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   wr_ready;
    logic [NUM_WORKERS-1:0] mc_jw_busy;
    logic [NUM_WORKERS-1:0] mc_jw_done;

    // Arbiter view.
    modport master (
        input  jw_mc_done, color_reg, addr_reg, wr_done,
        output wr_addr, wr_data, wr_ready, mc_jw_busy, mc_jw_done
    );

    // Workers + write port view.
    modport slave (
        output jw_mc_done, color_reg, addr_reg, wr_done,
        input  wr_addr, wr_data, wr_ready, mc_jw_busy, mc_jw_done
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick.
//   req       : request vector
//   mask      : requests to ignore this cycle
//   ptr       : index with highest priority
//   grant     : one-hot winner
//   grant_idx : index of the winner
//   any_grant : at least one eligible request
module rr_arbiter
    import julia_pkg::*;
(
    input  logic [NUM_WORKERS-1:0] req,
    input  logic [NUM_WORKERS-1:0] mask,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_WORKERS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   any_grant
);

    logic [NUM_WORKERS-1:0] eligible;

    assign eligible = req & ~mask;

    // Walk from ptr upward with wrap-around; first eligible index wins.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(i);
            if (sum >= (IDX_W+1)'(NUM_WORKERS)) begin
                sum = sum - (IDX_W+1)'(NUM_WORKERS);
            end
            cand = sum[IDX_W-1:0];
            if (!any_grant && eligible[cand]) begin
                any_grant   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_write_arbiter.sv
// Memory-write controller: grants one julia_worker at a time (round-robin),
// presents its pixel on the external write port, acknowledges the worker
// after wr_done and counts written pixels for frame completion.
//   clk, n_rst  : clock, asynchronous active-low reset
//   start_sig   : new-frame pulse; clears pixel count and frame_done
//   bus         : worker / write-port signals (master modport)
//   frame_done  : NUM_PIXELS writes completed since last start_sig
//   dbg_state   : current controller state
module mem_write_arbiter
    import julia_pkg::*;
#(
    parameter int NUM_PIXELS = julia_pkg::NUM_PIXELS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start_sig,
    mem_write_arbiter_if.master   bus,
    output logic                  frame_done,
    output mc_state_t             dbg_state
);

    localparam int              CNT_W   = $clog2(NUM_PIXELS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_PIXELS);

    mc_state_t              state;
    mc_state_t              state_next;
    logic                   do_grant;
    logic                   do_complete;

    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       grant_idx_q;
    logic [NUM_WORKERS-1:0] mask;
    logic [NUM_WORKERS-1:0] held_onehot;
    logic [CNT_W-1:0]       pix_cnt;

    logic [NUM_WORKERS-1:0] arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;

    rr_arbiter u_rr_arbiter (
        .req       (bus.jw_mc_done),
        .mask      (mask),
        .ptr       (ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    assign held_onehot = NUM_WORKERS'(1) << grant_idx_q;
    assign dbg_state   = state;

    // Next state; requests are only looked at in IDLE, wr_done only in WRITE.
    always_comb begin
        state_next  = state;
        do_grant    = 1'b0;
        do_complete = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    do_grant   = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (bus.wr_done) begin
                    do_complete = 1'b1;
                    state_next  = ACK;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Write-port and worker-side registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.wr_ready   <= 1'b0;
            bus.mc_jw_busy <= '0;
            bus.mc_jw_done <= '0;
            grant_idx_q    <= '0;
            ptr            <= '0;
            mask           <= '0;
        end else begin
            // The just-acknowledged worker may still have its request up in
            // the IDLE cycle after ACK; hide it for exactly that cycle.
            mask           <= (state == ACK) ? held_onehot : '0;
            bus.mc_jw_done <= '0;
            if (do_grant) begin
                bus.wr_addr    <= bus.addr_reg[arb_idx];
                bus.wr_data    <= bus.color_reg[arb_idx];
                bus.wr_ready   <= 1'b1;
                bus.mc_jw_busy <= arb_grant;
                grant_idx_q    <= arb_idx;
            end
            if (do_complete) begin
                bus.wr_ready   <= 1'b0;
                bus.mc_jw_busy <= '0;
                bus.mc_jw_done <= held_onehot;
                ptr            <= wrap_inc(grant_idx_q);
            end
        end
    end

    // Pixel counter; saturates at NUM_PIXELS, start_sig wins over a
    // completion in the same cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (start_sig) begin
            pix_cnt    <= '0;
            frame_done <= 1'b0;
        end else if (do_complete && (pix_cnt != CNT_MAX)) begin
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == CNT_MAX - 1'b1) begin
                frame_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_write_arbiter.sv
module tb_mem_write_arbiter;
    import julia_pkg::*;

    localparam int EW = 76; // {len[7:0], idx[3:0], addr[31:0], data[31:0]}

    logic      clk = 1'b0;
    logic      n_rst;
    logic      start_sig;
    logic      frame_done;
    mc_state_t dbg_state;

    mem_write_arbiter_if bus ();

    mem_write_arbiter #(.NUM_PIXELS(4)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start_sig  (start_sig),
        .bus        (bus),
        .frame_done (frame_done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int wr_delay = 0;
    int writes_seen = 0;
    logic [EW-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write-port responder: wr_done rises wr_delay cycles into the write.
    initial begin
        int wcnt;
        wcnt = 0;
        bus.wr_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst || !bus.wr_ready) begin
                wcnt = 0;
                bus.wr_done = 1'b0;
            end else begin
                wcnt++;
                bus.wr_done = (wcnt > wr_delay);
            end
        end
    end

    // Monitor: pops one expected write per wr_ready rise, checks the whole
    // transaction through to its acknowledge.
    initial begin
        logic          in_write;
        logic [EW-1:0] cur;
        logic [3:0]    cur_idx;
        logic [31:0]   lat_addr, lat_data;
        int            len;
        logic          unstable, busy_bad;
        in_write = 1'b0;
        cur = '0; cur_idx = '0; lat_addr = '0; lat_data = '0;
        len = 0; unstable = 1'b0; busy_bad = 1'b0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                in_write = 1'b0;
            end else if (bus.wr_ready && !in_write) begin
                if (exp_q.size() == 0) begin
                    cur = '0;
                    check("unexpected_write", 64'(bus.wr_ready), 64'(0));
                end else begin
                    cur = exp_q.pop_front();
                end
                cur_idx  = cur[67:64];
                lat_addr = bus.wr_addr;
                lat_data = bus.wr_data;
                check("wr_addr", 64'(bus.wr_addr), 64'(cur[63:32]));
                check("wr_data", 64'(bus.wr_data), 64'(cur[31:0]));
                check("busy_grant", 64'(bus.mc_jw_busy), 64'(16'(1) << cur_idx));
                check("done_in_write", 64'(bus.mc_jw_done), 64'(0));
                in_write = 1'b1;
                len = 1;
                unstable = 1'b0;
                busy_bad = 1'b0;
            end else if (bus.wr_ready && in_write) begin
                len++;
                if (bus.wr_addr !== lat_addr || bus.wr_data !== lat_data) unstable = 1'b1;
                if (bus.mc_jw_busy !== (16'(1) << cur_idx)) busy_bad = 1'b1;
            end else if (!bus.wr_ready && in_write) begin
                in_write = 1'b0;
                writes_seen++;
                check("ready_len", 64'(len), 64'(cur[75:68]));
                check("hold_stable", 64'(unstable), 64'(0));
                check("busy_held", 64'(busy_bad), 64'(0));
                check("ack_onehot", 64'(bus.mc_jw_done), 64'(16'(1) << cur_idx));
                check("busy_clear", 64'(bus.mc_jw_busy), 64'(0));
            end
        end
    end

    // One worker writes one pixel; it keeps its request one cycle past the ack.
    task automatic do_write(input int w, input logic [31:0] color, input logic [31:0] addr,
                            input int delay, input bit scramble, output logic fd_at_ack);
        bit got;
        got = 1'b0;
        fd_at_ack = 1'b0;
        wr_delay = delay;
        bus.color_reg[w] = color;
        bus.addr_reg[w]  = addr;
        exp_q.push_back({8'(delay + 1), 4'(w), addr, color});
        bus.jw_mc_done[w] = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) check("req_to_ready", 64'(bus.wr_ready), 64'(1));
            if (bus.mc_jw_done[w]) begin
                got = 1'b1;
                break;
            end
            if (scramble && bus.wr_ready) begin
                bus.color_reg[w] = $urandom;
                bus.addr_reg[w]  = $urandom;
            end
        end
        check("ack_seen", 64'(got), 64'(1));
        fd_at_ack = frame_done;
        repeat (2) @(negedge clk);
        check("no_regrant", 64'(bus.wr_ready), 64'(0));
        bus.jw_mc_done[w] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        logic fd;
        int   acks, first_c, last_c;
        bit   got;
        n_rst = 1'b0;
        start_sig = 1'b0;
        bus.jw_mc_done = '0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            bus.color_reg[i] = '0;
            bus.addr_reg[i]  = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(bus.wr_ready), 64'(0));
        check("rst_busy", 64'(bus.mc_jw_busy), 64'(0));
        check("rst_done", 64'(bus.mc_jw_done), 64'(0));
        check("rst_addr", 64'(bus.wr_addr), 64'(0));
        check("rst_data", 64'(bus.wr_data), 64'(0));
        check("rst_frame", 64'(frame_done), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        n_rst = 1'b1;
        @(negedge clk);

        // Fairness: all 16 requesting, wr_done immediate.
        wr_delay = 0;
        for (int i = 0; i < NUM_WORKERS; i++) begin
            bus.color_reg[i] = 32'hC000_0000 + 32'(i);
            bus.addr_reg[i]  = 32'h0000_1000 + 32'(i * 4);
        end
        for (int i = 0; i <= NUM_WORKERS; i++) begin
            int k;
            k = i % NUM_WORKERS;
            exp_q.push_back({8'd1, 4'(k), 32'h0000_1000 + 32'(k * 4), 32'hC000_0000 + 32'(k)});
        end
        bus.jw_mc_done = '1;
        acks = 0; first_c = 0; last_c = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (|bus.mc_jw_done) begin
                acks++;
                if (acks == 1) first_c = c;
                if (acks == 17) begin
                    last_c = c;
                    bus.jw_mc_done = '0;
                    break;
                end
            end
        end
        check("fair_acks", 64'(acks), 64'(17));
        check("fair_spacing", 64'(last_c - first_c), 64'(48));
        repeat (3) @(negedge clk);
        check("frame_after_fair", 64'(frame_done), 64'(1));

        // Single request, worker 0, wr_ready held 3 cycles.
        do_write(0, 32'hFF00_FF00, 32'h0000_0100, 2, 1'b0, fd);
        // Mask: worker 5 keeps requesting one cycle past its ack.
        do_write(5, 32'h5555_0005, 32'h0000_0500, 0, 1'b0, fd);
        // Hold stability under changing inputs, wr_done after 10 cycles.
        do_write(9, 32'h9999_0009, 32'h0000_0900, 10, 1'b1, fd);

        // Frame count with NUM_PIXELS = 4.
        start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        check("start_clears", 64'(frame_done), 64'(0));
        do_write(1, 32'hA000_0001, 32'h0000_2001, 1, 1'b0, fd);
        do_write(2, 32'hA000_0002, 32'h0000_2002, 1, 1'b0, fd);
        do_write(3, 32'hA000_0003, 32'h0000_2003, 1, 1'b0, fd);
        check("frame_after_3", 64'(fd), 64'(0));
        do_write(4, 32'hA000_0004, 32'h0000_2004, 1, 1'b0, fd);
        check("frame_after_4", 64'(fd), 64'(1));
        do_write(6, 32'hA000_0006, 32'h0000_2006, 1, 1'b0, fd);
        check("frame_after_5", 64'(fd), 64'(1));
        start_sig = 1'b1;
        @(negedge clk);
        start_sig = 1'b0;
        check("start_drops_frame", 64'(frame_done), 64'(0));

        // Reset in the middle of a write.
        wr_delay = 20;
        bus.color_reg[3] = 32'h3333_3333;
        bus.addr_reg[3]  = 32'h0000_3333;
        exp_q.push_back({8'd21, 4'd3, 32'h0000_3333, 32'h3333_3333});
        bus.jw_mc_done[3] = 1'b1;
        @(negedge clk);
        check("pre_rst_ready", 64'(bus.wr_ready), 64'(1));
        #2;
        n_rst = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bus.wr_ready), 64'(0));
        check("mid_rst_busy", 64'(bus.mc_jw_busy), 64'(0));
        check("mid_rst_done", 64'(bus.mc_jw_done), 64'(0));
        check("mid_rst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        bus.jw_mc_done = '0;
        n_rst = 1'b1;
        @(negedge clk);
        wr_delay = 0;
        bus.color_reg[0]  = 32'h0BAD_0000;
        bus.addr_reg[0]   = 32'h0000_7000;
        bus.color_reg[15] = 32'h0BAD_000F;
        bus.addr_reg[15]  = 32'h0000_700F;
        exp_q.push_back({8'd1, 4'd0, 32'h0000_7000, 32'h0BAD_0000});
        bus.jw_mc_done = 16'h8001;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (|bus.mc_jw_done) begin
                got = 1'b1;
                check("post_rst_winner", 64'(bus.mc_jw_done), 64'(16'h0001));
                bus.jw_mc_done = '0;
                break;
            end
        end
        check("post_rst_ack", 64'(got), 64'(1));

        repeat (5) @(negedge clk);
        check("exp_q_empty", 64'(exp_q.size()), 64'(0));
        check("writes_total", 64'(writes_seen), 64'(26));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
